// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// ----------------
// Hazard and stall sequencer for the 5-stage pipeline. Each cycle it decides
// whether to hold the whole pipe (slow data memory, or a timed-out memory
// error), flush the front end (taken branch), or freeze IF and insert a
// bubble into ID/EXE (read-after-write hazard). It also owns the
// forwarding-unit enable, a memory-wait watchdog and saturating counters.
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   fwd_mode                 requested forwarding mode (1 forward, 0 interlock)
//   id_src1, id_src2         ID-stage source registers
//   id_two_src               id_src2 is a real operand
//   exe_dest, exe_wb_en      EXE-stage destination and write-back enable
//   exe_mem_r_en             EXE holds a load
//   mem_dest, mem_wb_en      MEM-stage destination and write-back enable
//   mem_req, mem_ready       MEM access request / acknowledge
//   branch_taken             EXE resolved a taken branch
//   freeze_if, bubble_id     hold PC/IF-ID, load NOP into ID/EXE
//   flush                    clear IF/ID and ID/EXE
//   stall_all                hold every pipeline register
//   fwd_enable               enable to the forwarding unit
//   state                    0 RUN, 1 MEM_WAIT, 2 ERROR
//   mem_timeout              sticky memory-timeout flag
//   stall_cycles             saturating count of stall/bubble cycles
//   flush_count              saturating count of flush cycles
module hazard_sequencer #(
    parameter int   MEM_TIMEOUT = 64,
    parameter logic FWD_RESET   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fwd_mode,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        freeze_if,
    output logic        bubble_id,
    output logic        flush,
    output logic        stall_all,
    output logic        fwd_enable,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles,
    output logic [7:0]  flush_count
);

    localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [WCW-1:0] wait_cnt_reg;
    logic           fwd_enable_reg;
    logic           mem_timeout_reg;
    logic           raw_exe;
    logic           raw_mem;
    logic           hazard;
    logic           mem_blocked;

    function automatic logic hit(input logic [3:0] d);
        return (id_src1 == d) || (id_two_src && (id_src2 == d));
    endfunction

    assign raw_exe     = exe_wb_en && hit(exe_dest);
    assign raw_mem     = mem_wb_en && hit(mem_dest);
    // With forwarding only a load in EXE cannot be bypassed; without it any
    // in-flight producer in EXE or MEM must be waited out.
    assign hazard      = fwd_enable_reg ? (raw_exe && exe_mem_r_en) : (raw_exe || raw_mem);
    assign mem_blocked = mem_req && !mem_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (mem_blocked) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                end else if (wait_cnt_reg == WCW'(MEM_TIMEOUT - 1)) begin
                    state_next = ERROR;
                end
            end
            ERROR:   state_next = ERROR;
            default: state_next = RUN;
        endcase
    end

    // Output logic: stall_all beats flush beats hazard. All control strobes
    // are forced low while reset is asserted.
    always_comb begin
        stall_all = 1'b0;
        flush     = 1'b0;
        freeze_if = 1'b0;
        bubble_id = 1'b0;
        if (rst_n) begin
            if ((state_reg == ERROR) || mem_blocked) begin
                stall_all = 1'b1;
            end else if (branch_taken) begin
                flush = 1'b1;
            end else if (hazard) begin
                freeze_if = 1'b1;
                bubble_id = 1'b1;
            end
        end
    end

    // Watchdog: counts MEM_WAIT cycles without an acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == MEM_WAIT) && !mem_ready) begin
            wait_cnt_reg <= wait_cnt_reg + WCW'(1);
        end
    end

    // Forwarding mode changes only on a quiet cycle so an in-flight hazard
    // decision is never re-evaluated under a different rule mid-stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_enable_reg <= FWD_RESET;
        end else if (!stall_all && !hazard) begin
            fwd_enable_reg <= fwd_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout_reg <= 1'b0;
        end else if (state_next == ERROR) begin
            mem_timeout_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((stall_all || bubble_id) && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (flush && (flush_count != 8'hFF)) begin
                flush_count <= flush_count + 8'd1;
            end
        end
    end

    assign state       = state_reg;
    assign fwd_enable  = fwd_enable_reg;
    assign mem_timeout = mem_timeout_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

    localparam int MT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fwd_mode = 1'b1;
    logic [3:0]  id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic        id_two_src = 1'b0, exe_wb_en = 1'b0, exe_mem_r_en = 1'b0, mem_wb_en = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
    logic        freeze_if, bubble_id, flush, stall_all, fwd_enable, mem_timeout;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;

    int compared = 0;
    int mismatched = 0;

    hazard_sequencer #(.MEM_TIMEOUT(MT), .FWD_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .fwd_mode(fwd_mode),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .freeze_if(freeze_if), .bubble_id(bubble_id), .flush(flush), .stall_all(stall_all),
        .fwd_enable(fwd_enable), .state(state), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int   m_state;   // 0 run, 1 waiting on memory, 2 error
    int   m_waited;  // memory-wait cycles seen without ack
    logic m_fwd;
    logic m_to;
    int   m_stalls;
    int   m_flushes;
    logic e_hazard, e_stall, e_flush, e_bubble;

    function automatic logic reads(input logic [3:0] d);
        return (id_src1 == d) || (id_two_src && id_src2 == d);
    endfunction

    always_comb begin
        e_hazard = 1'b0;
        e_stall  = 1'b0;
        e_flush  = 1'b0;
        e_bubble = 1'b0;
        if (m_fwd) e_hazard = exe_wb_en && exe_mem_r_en && reads(exe_dest);
        else       e_hazard = (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
        if (rst_n) begin
            e_stall  = (m_state == 2) || (mem_req && !mem_ready);
            e_flush  = !e_stall && branch_taken;
            e_bubble = !e_stall && !branch_taken && e_hazard;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_waited <= 0; m_fwd <= 1'b1; m_to <= 1'b0;
            m_stalls <= 0; m_flushes <= 0;
        end else begin
            if (m_state == 0) begin
                m_waited <= 0;
                if (mem_req && !mem_ready) m_state <= 1;
            end else if (m_state == 1) begin
                if (!mem_ready) m_waited <= m_waited + 1;
                if (mem_ready) m_state <= 0;
                else if (m_waited + 1 >= MT) begin
                    m_state <= 2;
                    m_to <= 1'b1;
                end
            end
            if (!e_stall && !e_hazard) m_fwd <= fwd_mode;
            if (e_stall || e_bubble) m_stalls <= (m_stalls < 65535) ? m_stalls + 1 : 65535;
            if (e_flush) m_flushes <= (m_flushes < 255) ? m_flushes + 1 : 255;
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fwd_mode = 1'b1; id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        mem_req = 1'b1;          // would stall if reset did not force outputs
        branch_taken = 1'b1;
        @(negedge clk);
        compared++;
        if ({freeze_if, bubble_id, flush, stall_all} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 0000", {freeze_if, bubble_id, flush, stall_all});
        end
        compared++;
        if (state !== 2'd0 || fwd_enable !== 1'b1 || mem_timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_regs: state=%0d fwd=%b to=%b want 0 1 0", state, fwd_enable, mem_timeout);
        end
        compared++;
        if (stall_cycles !== 16'd0 || flush_count !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_counts: stall=%0d flush=%0d want 0 0", stall_cycles, flush_count);
        end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        fwd_mode = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; id_src1 = 4'd3;
        mem_dest = 4'd9;
        @(negedge clk);
        compared++;
        if (freeze_if !== 1'b1 || bubble_id !== 1'b1) begin
            mismatched++;
            $display("FAIL load_use_bubble: freeze=%b bubble=%b want 1 1", freeze_if, bubble_id);
        end
        tick();
        // load has advanced to MEM: forwarding covers it
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = 4'd3; mem_wb_en = 1'b1;
        @(negedge clk);
        compared++;
        if (bubble_id !== 1'b0 || freeze_if !== 1'b0) begin
            mismatched++;
            $display("FAIL load_use_release: freeze=%b bubble=%b want 0 0", freeze_if, bubble_id);
        end
        compared++;
        if (stall_cycles !== 16'd1) begin
            mismatched++;
            $display("FAIL load_use_count: stall_cycles=%0d want 1", stall_cycles);
        end
        $display("test_load_use done");
    endtask

    task automatic test_interlock();
        do_reset();
        fwd_mode = 1'b0;
        tick();
        @(negedge clk);
        compared++;
        if (fwd_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL interlock_latch: fwd_enable=%b want 0", fwd_enable);
        end
        mem_dest = 4'd5; mem_wb_en = 1'b1; id_two_src = 1'b1; id_src2 = 4'd5; id_src1 = 4'd1;
        fwd_mode = 1'b1;         // must not load while the hazard is present
        tick();
        @(negedge clk);
        compared++;
        if (bubble_id !== 1'b1 || fwd_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL interlock_bubble: bubble=%b fwd=%b want 1 0", bubble_id, fwd_enable);
        end
        mem_wb_en = 1'b0;        // quiet cycle lets fwd_mode=1 load
        tick();
        mem_wb_en = 1'b1;
        @(negedge clk);
        compared++;
        if (fwd_enable !== 1'b1 || bubble_id !== 1'b0) begin
            mismatched++;
            $display("FAIL forward_no_bubble: fwd=%b bubble=%b want 1 0", fwd_enable, bubble_id);
        end
        $display("test_interlock done");
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (stall_all !== 1'b1 || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                mismatched++;
                $display("FAIL mem_wait_%0d: stall=%b state=%0d want 1 %0d", i, stall_all, state, (i == 0) ? 0 : 1);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (stall_all !== 1'b0 || state !== 2'd1) begin
            mismatched++;
            $display("FAIL mem_release: stall=%b state=%0d want 0 1", stall_all, state);
        end
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        compared++;
        if (state !== 2'd0 || stall_cycles !== 16'd3) begin
            mismatched++;
            $display("FAIL mem_after: state=%0d stall_cycles=%0d want 0 3", state, stall_cycles);
        end
        $display("test_mem_wait done");
    endtask

    task automatic test_branch_stall();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++;
            if (flush !== 1'b0 || stall_all !== 1'b1) begin
                mismatched++;
                $display("FAIL branch_held_%0d: flush=%b stall=%b want 0 1", i, flush, stall_all);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (flush !== 1'b1 || stall_all !== 1'b0) begin
            mismatched++;
            $display("FAIL branch_release: flush=%b stall=%b want 1 0", flush, stall_all);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        compared++;
        if (flush_count !== 8'd1 || stall_cycles !== 16'd2) begin
            mismatched++;
            $display("FAIL branch_counts: flush_count=%0d stall_cycles=%0d want 1 2", flush_count, stall_cycles);
        end
        $display("test_branch_stall done");
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        // one RUN cycle plus MT wait cycles
        for (int i = 0; i <= MT; i++) begin
            @(negedge clk);
            compared++;
            if (stall_all !== 1'b1 || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                mismatched++;
                $display("FAIL timeout_wait_%0d: stall=%b state=%0d", i, stall_all, state);
            end
            tick();
        end
        mem_ready = 1'b1;        // an ack no longer helps
        @(negedge clk);
        compared++;
        if (state !== 2'd2 || mem_timeout !== 1'b1 || stall_all !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_error: state=%0d to=%b stall=%b want 2 1 1", state, mem_timeout, stall_all);
        end
        compared++;
        if (stall_cycles !== 16'(MT + 1)) begin
            mismatched++;
            $display("FAIL timeout_count: stall_cycles=%0d want %0d", stall_cycles, MT + 1);
        end
        #2;
        rst_n = 1'b0;            // asynchronous, away from any clock edge
        #1;
        compared++;
        if (state !== 2'd0 || mem_timeout !== 1'b0 || stall_all !== 1'b0 || stall_cycles !== 16'd0
            || fwd_enable !== 1'b1) begin
            mismatched++;
            $display("FAIL async_reset: state=%0d to=%b stall=%b cnt=%0d fwd=%b", state, mem_timeout,
                     stall_all, stall_cycles, fwd_enable);
        end
        do_reset();
        $display("test_timeout done");
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (70000) tick();
        @(negedge clk);
        compared++;
        if (stall_cycles !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL stall_saturate: stall_cycles=%h want ffff", stall_cycles);
        end
        do_reset();
        branch_taken = 1'b1;
        repeat (300) tick();
        @(negedge clk);
        compared++;
        if (flush_count !== 8'hFF || stall_cycles !== 16'd0) begin
            mismatched++;
            $display("FAIL flush_saturate: flush_count=%h stall_cycles=%0d want ff 0", flush_count, stall_cycles);
        end
        $display("test_saturation done");
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = mismatched;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            fwd_mode     = ($urandom_range(0, 3) != 0);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_dest     = 4'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_dest     = 4'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ready    = ($urandom_range(0, 2) != 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            compared++;
            if ({freeze_if, bubble_id, flush, stall_all} !== {e_bubble, e_bubble, e_flush, e_stall}) begin
                mismatched++;
                $display("FAIL rand_ctrl@%0d: got %b want %b", n, {freeze_if, bubble_id, flush, stall_all},
                         {e_bubble, e_bubble, e_flush, e_stall});
            end
            compared++;
            if (state !== 2'(m_state) || fwd_enable !== m_fwd || mem_timeout !== m_to) begin
                mismatched++;
                $display("FAIL rand_regs@%0d: state=%0d fwd=%b to=%b want %0d %b %b", n, state, fwd_enable,
                         mem_timeout, m_state, m_fwd, m_to);
            end
            compared++;
            if (stall_cycles !== 16'(m_stalls) || flush_count !== 8'(m_flushes)) begin
                mismatched++;
                $display("FAIL rand_counts@%0d: stall=%0d flush=%0d want %0d %0d", n, stall_cycles,
                         flush_count, m_stalls, m_flushes);
            end
            tick();
        end
        rst_n = 1'b1;
        $display("test_random done, new mismatches %0d", mismatched - errs_before);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_interlock();
        test_mem_wait();
        test_branch_stall();
        test_timeout();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall sequencer for the 5-stage ARM core. It decides each cycle whether the front end freezes, a bubble enters ID/EXE, the front end is flushed, or the whole pipeline holds for a slow data-memory access. It also drives the enable of the forwarding unit, sequences memory-wait stalls with a timeout watchdog, and keeps saturating stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 64: consecutive memory-wait cycles that trigger the timeout error state.
- FWD_RESET, 1: reset value of fwd_enable.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fwd_mode  in  1  requested forwarding mode (1 = forward, 0 = full interlock).
- id_src1, id_src2  in  4  ID-stage source register numbers.
- id_two_src  in  1  id_src2 is a real operand.
- exe_dest  in  4  EXE-stage destination; exe_wb_en  in  1; exe_mem_r_en  in  1 (EXE holds a load).
- mem_dest  in  4  MEM-stage destination; mem_wb_en  in  1.
- mem_req  in  1  MEM stage is issuing a load/store; mem_ready  in  1  memory acknowledges this cycle.
- branch_taken  in  1  EXE resolved a taken branch.
- freeze_if  out  1  hold PC and IF/ID.
- bubble_id  out  1  load NOP into ID/EXE.
- flush  out  1  clear IF/ID and ID/EXE.
- stall_all  out  1  hold every pipeline register.
- fwd_enable  out  1  enable to forwarding unit.
- state  out  2  0 RUN, 1 MEM_WAIT, 2 ERROR.
- mem_timeout  out  1  sticky timeout flag.
- stall_cycles  out  16  saturating stall counter.
- flush_count  out  8  saturating flush counter.

## Operation
- Hazard terms: hit_x(d) = (id_src1 == d) || (id_two_src && id_src2 == d); raw_exe = exe_wb_en && hit_x(exe_dest); raw_mem = mem_wb_en && hit_x(mem_dest).
- hazard = fwd_enable ? (raw_exe && exe_mem_r_en) : (raw_exe || raw_mem).
- FSM: RUN -> MEM_WAIT when mem_req && !mem_ready; MEM_WAIT -> RUN when mem_ready; MEM_WAIT -> ERROR when wait_cnt reaches MEM_TIMEOUT-1 and mem_ready = 0; ERROR is terminal until reset.
- stall_all = (state == ERROR) || (mem_req && !mem_ready) in RUN/MEM_WAIT.
- Priority per cycle: stall_all > flush > hazard.
  - stall_all = 1: freeze_if = bubble_id = flush = 0 (whole pipe held; pending branch stays in EXE and flushes once released).
  - else branch_taken: flush = 1, freeze_if = bubble_id = 0.
  - else hazard: freeze_if = bubble_id = 1.
- wait_cnt (internal): clears in RUN, increments each MEM_WAIT cycle with mem_ready = 0.
- fwd_enable: loads fwd_mode on each clock edge where stall_all = 0 and hazard = 0; otherwise holds.
- mem_timeout = 1 from entry to ERROR until reset.
- stall_cycles increments (saturating at 0xFFFF) each cycle with stall_all || bubble_id; flush_count increments (saturating at 0xFF) each cycle with flush.

## Timing
- freeze_if, bubble_id, flush, stall_all: combinational from inputs and registered state, valid in the same cycle; pipeline registers act on the next rising edge.
- While rst_n = 0: state = RUN, wait_cnt = 0, fwd_enable = FWD_RESET, mem_timeout = 0, counters = 0, and freeze_if/bubble_id/flush/stall_all forced to 0.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately (asynchronous).
- Load-use costs exactly one bubble: the next cycle the load is in MEM, so hazard drops.
- mem_req with mem_ready in the same cycle: no stall, stays RUN.
- mem_ready returning: stall_all drops in that same cycle; state reads RUN after the edge.
- Counter updates, fwd_enable and state changes are visible one cycle after the qualifying cycle.

## Test plan
- fwd_mode = 1, exe_dest = 3, exe_wb_en = 1, exe_mem_r_en = 1, id_src1 = 3 -> freeze_if = bubble_id = 1 for one cycle; stall_cycles = 1 afterwards.
- fwd_mode = 0 (latched), mem_dest = 5, mem_wb_en = 1, id_two_src = 1, id_src2 = 5 -> bubble_id = 1; with fwd_mode = 1 the same inputs -> no bubble.
- mem_req = 1, mem_ready low for 3 cycles -> stall_all = 1 for 3 cycles, state = 1, then 0 when mem_ready = 1; stall_cycles = 3.
- branch_taken = 1 during a memory stall -> flush = 0 while stall_all = 1, flush = 1 in the release cycle, flush_count = 1.
- MEM_TIMEOUT = 4, mem_ready held 0 -> state = 2 and mem_timeout = 1 after 4 wait cycles, stall_all stays 1; asynchronous rst_n pulse -> state = 0 and all outputs at reset values.
- 70000 stall cycles -> stall_cycles saturates at 0xFFFF; 300 flushes -> flush_count saturates at 0xFF.
